// File: rtl/lfsr_bist_pkg.sv
// Shared types and constants for the LFSR/MISR built-in self-test controller.
package lfsr_bist_pkg;

   localparam int BIST_W = 4;

   // Feedback taps as bit masks over the register (x^4 + x^3 + 1).
   localparam logic [BIST_W-1:0] LFSR_TAPS = 4'b1100;
   localparam logic [BIST_W-1:0] MISR_TAPS = 4'b1100;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   function automatic logic [BIST_W-1:0] fb_shift(input logic [BIST_W-1:0] v,
                                                  input logic [BIST_W-1:0] taps);
      return {v[BIST_W-2:0], ^(v & taps)};
   endfunction

endpackage

// File: rtl/bist_misr.sv
// 4-bit multiple-input signature register: clr has priority over en.
module bist_misr
   import lfsr_bist_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [BIST_W-1:0] din,
   output logic [BIST_W-1:0] sig
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig <= '0;
      end else if (clr) begin
         sig <= '0;
      end else if (en) begin
         sig <= fb_shift(sig, MISR_TAPS) ^ din;
      end
   end

endmodule

// File: rtl/lfsr_bist_ctrl.sv
// BIST sequencer: LFSR pattern source, MISR compaction, golden-signature check.
// Optional abort port enabled by defining LFSR_BIST_ABORT_EN.
module lfsr_bist_ctrl
   import lfsr_bist_pkg::*;
#(
   parameter logic [BIST_W-1:0] SEED    = 4'b1111,
   parameter int                NUM_PAT = 15,
   parameter int                CNT_W   = 4,
   parameter logic [BIST_W-1:0] GOLDEN  = 4'b0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
`ifdef LFSR_BIST_ABORT_EN
   input  logic              abort,
`endif
   input  logic [BIST_W-1:0] cut_resp,
   output logic [BIST_W-1:0] pat_out,
   output logic              pat_valid,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [BIST_W-1:0] signature,
   output state_t            dbg_state
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PAT - 1);

   // Handshake: start is a level sampled only in IDLE; done is a one-cycle
   // pulse, and pass/signature stay valid from done until the next accepted start.

   state_t            state;
   logic [BIST_W-1:0] lfsr;
   logic [CNT_W-1:0]  cnt;
   logic              abort_req;
   logic              misr_clr;
   logic              misr_en;

`ifdef LFSR_BIST_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // An abort in LOAD/RUN must leave the MISR untouched, hence the gating.
   assign misr_clr = (state == ST_LOAD) && !abort_req;
   assign misr_en  = (state == ST_RUN)  && !abort_req;

   bist_misr u_misr (
      .clk (clk),
      .rst (rst),
      .clr (misr_clr),
      .en  (misr_en),
      .din (cut_resp),
      .sig (signature)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         lfsr      <= SEED;
         cnt       <= '0;
         pat_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort_req && (state == ST_LOAD || state == ST_RUN || state == ST_CHECK)) begin
            state     <= ST_IDLE;
            pat_valid <= 1'b0;
            busy      <= 1'b0;
            pass      <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && !abort_req) begin
                     state <= ST_LOAD;
                     busy  <= 1'b1;
                     pass  <= 1'b0;
                  end
               end
               ST_LOAD: begin
                  lfsr      <= SEED;
                  cnt       <= '0;
                  state     <= ST_RUN;
                  pat_valid <= 1'b1;
               end
               ST_RUN: begin
                  lfsr <= fb_shift(lfsr, LFSR_TAPS);
                  cnt  <= cnt + 1'b1;
                  if (cnt == LAST_CNT) begin
                     state     <= ST_CHECK;
                     pat_valid <= 1'b0;
                  end
               end
               ST_CHECK: begin
                  pass  <= (signature == GOLDEN);
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
               ST_DONE: begin
                  state <= ST_IDLE;
               end
               default: begin
                  state     <= ST_IDLE;
                  pat_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pat_out   = lfsr;
   assign dbg_state = state;

endmodule
